// File: rtl/bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_pkg : shared types and constants for the MEM-stage bridge    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DM_RD    = 2'd1,
    ST_DEV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  localparam logic [31:0] DEF_DM_TOP      = 32'h0000_2fff;
  localparam logic [31:0] DEF_TC0_BASE    = 32'h0000_7f00;
  localparam logic [31:0] DEF_TC1_BASE    = 32'h0000_7f10;
  localparam int          DEF_DEV_TIMEOUT = 16;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_bridge_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_bus_bridge_if : CPU, DM and timer-device signals of bridge   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface mem_bus_bridge_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic        flush;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic [4:0]  excode;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dev_req;
  logic        dev_sel;
  logic [1:0]  dev_reg;
  logic        dev_we;
  logic [31:0] dev_wdata;
  logic        dev_ready;
  logic [31:0] dev_rdata;

  modport master (
    output req, we, size, sign_ext, flush, addr, wdata, dm_rdata, dev_ready, dev_rdata,
    input  rdata, stall, excode, dm_we, dm_be, dm_addr, dm_wdata,
           dev_req, dev_sel, dev_reg, dev_we, dev_wdata
  );

  modport slave (
    input  req, we, size, sign_ext, flush, addr, wdata, dm_rdata, dev_ready, dev_rdata,
    output rdata, stall, excode, dm_we, dm_be, dm_addr, dm_wdata,
           dev_req, dev_sel, dev_reg, dev_we, dev_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_align : lane select and sign/zero extension of load data    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module load_align
  import bus_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (byte_off)
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      2'd3:    w_byte = word[31:24];
      default: w_byte = word[7:0];
    endcase
    w_half = byte_off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: data = {{16{sign_ext & w_half[15]}}, w_half};
      default: data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_bus_bridge : MEM-stage decode, exceptions, DM/timer sequencer |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_bus_bridge
  import bus_pkg::*;
#(
  parameter logic [31:0] DM_TOP      = DEF_DM_TOP,
  parameter logic [31:0] TC0_BASE    = DEF_TC0_BASE,
  parameter logic [31:0] TC1_BASE    = DEF_TC1_BASE,
  parameter int          DEV_TIMEOUT = DEF_DEV_TIMEOUT
)(
  input  logic              clk,
  input  logic              reset,
  mem_bus_bridge_if.slave   bus
);

  // Timeout fires on the counter value seen in the last allowed DEV_WAIT cycle.
  localparam logic [7:0] c_cnt_last = 8'(DEV_TIMEOUT - 2);

  state_t      r_state;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;
  logic        r_bus_err;
  logic        r_dev_sel;
  logic [1:0]  r_dev_reg;
  logic        r_dev_we;
  logic [31:0] r_dev_wdata;

  logic        w_dm_hit;
  logic        w_tc0_hit;
  logic        w_tc1_hit;
  logic        w_tc_hit;
  logic [1:0]  w_tc_word;
  logic        w_size_word;
  logic        w_misalign;
  logic        w_bad;
  logic        w_idle;
  logic        w_exc;
  logic        w_take;
  logic        w_dm_store;
  logic        w_dm_load;
  logic        w_dev_acc;
  logic        w_dev_req;
  logic [31:0] w_align_word;
  logic [1:0]  w_align_size;
  logic [31:0] w_align_data;

  assign w_dm_hit    = bus.addr <= DM_TOP;
  assign w_tc0_hit   = (bus.addr >= TC0_BASE) && (bus.addr <= TC0_BASE + 32'd11);
  assign w_tc1_hit   = (bus.addr >= TC1_BASE) && (bus.addr <= TC1_BASE + 32'd11);
  assign w_tc_hit    = w_tc0_hit | w_tc1_hit;
  assign w_tc_word   = w_tc1_hit ? (bus.addr[3:2] - TC1_BASE[3:2]) : (bus.addr[3:2] - TC0_BASE[3:2]);
  assign w_size_word = bus.size[1];
  assign w_misalign  = (w_size_word & (|bus.addr[1:0])) | ((bus.size == SZ_HALF) & bus.addr[0]);

  // Timers are word-only, and their COUNT register (word 2) is read-only.
  assign w_bad = w_misalign | ~(w_dm_hit | w_tc_hit) | (w_tc_hit & ~w_size_word)
               | (w_tc_hit & bus.we & (w_tc_word == 2'd2));

  assign w_idle     = r_state == ST_IDLE;
  assign w_exc      = w_idle & bus.req & w_bad;
  assign w_take     = w_idle & bus.req & ~w_bad & ~bus.flush;
  assign w_dm_store = w_take & w_dm_hit & bus.we;
  assign w_dm_load  = w_take & w_dm_hit & ~bus.we;
  assign w_dev_acc  = w_take & w_tc_hit;
  assign w_dev_req  = (r_state == ST_DEV_WAIT) & ~bus.flush;

  assign bus.stall = ~bus.flush & (w_dm_load | w_dev_acc
                                   | (r_state == ST_DM_RD) | (r_state == ST_DEV_WAIT));
  assign bus.excode = w_exc ? (bus.we ? EXC_ADES : EXC_ADEL)
                    : ((r_state == ST_DONE) && r_bus_err) ? EXC_DBE : EXC_NONE;
  assign bus.rdata  = r_rdata;

  assign bus.dm_we    = w_dm_store;
  assign bus.dm_be    = w_dm_store ? byte_enables(bus.size, bus.addr[1:0]) : 4'b0000;
  assign bus.dm_wdata = w_dm_store ? lane_replicate(bus.size, bus.wdata) : 32'd0;
  assign bus.dm_addr  = bus.addr[13:2];

  assign bus.dev_req   = w_dev_req;
  assign bus.dev_sel   = r_dev_sel;
  assign bus.dev_reg   = r_dev_reg;
  assign bus.dev_we    = r_dev_we & w_dev_req;
  assign bus.dev_wdata = r_dev_wdata;

  assign w_align_word = (r_state == ST_DEV_WAIT) ? bus.dev_rdata : bus.dm_rdata;
  assign w_align_size = (r_state == ST_DEV_WAIT) ? SZ_WORD : bus.size;

  load_align u_load_align (
    .word     (w_align_word),
    .byte_off (bus.addr[1:0]),
    .size     (w_align_size),
    .sign_ext (bus.sign_ext),
    .data     (w_align_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rdata     <= 32'd0;
      r_cnt       <= 8'd0;
      r_bus_err   <= 1'b0;
      r_dev_sel   <= 1'b0;
      r_dev_reg   <= 2'd0;
      r_dev_we    <= 1'b0;
      r_dev_wdata <= 32'd0;
    end else if (bus.flush) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_dm_load) begin
            r_state <= ST_DM_RD;
          end else if (w_dev_acc) begin
            r_state     <= ST_DEV_WAIT;
            r_cnt       <= 8'd0;
            r_bus_err   <= 1'b0;
            r_dev_sel   <= w_tc1_hit;
            r_dev_reg   <= bus.addr[3:2];
            r_dev_we    <= bus.we;
            r_dev_wdata <= bus.wdata;
          end
        end
        ST_DM_RD: begin
          r_rdata <= w_align_data;
          r_state <= ST_DONE;
        end
        ST_DEV_WAIT: begin
          // Ready in the limit cycle still completes the access normally.
          if (bus.dev_ready) begin
            if (!r_dev_we) r_rdata <= w_align_data;
            r_state <= ST_DONE;
          end else if (r_cnt == c_cnt_last) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_bus_err <= 1'b0;
          r_cnt     <= 8'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Memory-stage bus controller for the pipelined MIPS core. It decodes each MEM-stage load or store and raises address exceptions. Legal accesses are sequenced to the data memory (DM) or to one of two timer devices. The block stalls the pipeline until the data is ready, then returns the aligned and extended load data to the M/W boundary.

## Interface
Parameters:
- DM_TOP, 32'h0000_2fff, last byte address of DM; DM spans 0..DM_TOP
- TC0_BASE, 32'h0000_7f00, timer 0 base; it owns 3 word registers at offsets 0, 4, 8
- TC1_BASE, 32'h0000_7f10, timer 1 base; same 3-register layout
- DEV_TIMEOUT, 16, cycles to wait for dev_ready before a bus error; range 2..255

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  MEM stage holds a valid load/store; held stable while stall=1
- we  in  1  1=store, 0=load
- size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- sign_ext  in  1  loads only: 1 selects sign extension, 0 selects zero extension
- flush  in  1  exception flush from CP0; aborts any access in flight
- addr  in  32  byte address (AO_M)
- wdata  in  32  store data (RT_M)
- rdata  out  32  load result, valid in the DONE cycle
- stall  out  1  freezes F/D/E/M
- excode  out  5  0, 4 (AdEL), 5 (AdES) or 7 (bus error)
- dm_we  out  1  DM write strobe
- dm_be  out  4  DM byte enables
- dm_addr  out  12  DM word address, addr[13:2]
- dm_wdata  out  32  store data replicated to the lanes
- dm_rdata  in  32  DM read data, valid one cycle after dm_addr
- dev_req  out  1  timer access request
- dev_sel  out  1  0=timer 0, 1=timer 1
- dev_reg  out  2  register index, addr[3:2]
- dev_we  out  1  device write
- dev_wdata  out  32  device write data
- dev_ready  in  1  device completes the access this cycle
- dev_rdata  in  32  device read data, valid while dev_ready=1

## Operation
Address decode (combinational, on req):
- DM hit: addr <= DM_TOP.
- TCn hit: addr is in [base, base+11].
- Misalignment: a word access with addr[1:0]≠0, or a half access with addr[0]≠0.
- A load raises AdEL (4), and a store raises AdES (5), on any of:
  - misalignment;
  - no decode hit;
  - a byte or half access to a timer;
  - a store to timer offset 8 (COUNT, read-only).
- An exception is reported in the same cycle as req. stall=0 and no DM or device strobe is driven.

States: IDLE, DM_RD, DEV_WAIT, DONE.
- IDLE, DM store: dm_we=1 with dm_be derived from size and address:
  - word: 1111;
  - half: 0011 << (2·addr[1]);
  - byte: 0001 << addr[1:0].
  - The state stays IDLE and stall=0.
- IDLE, DM load: stall=1, next state DM_RD.
- IDLE, timer access: stall=1, next state DEV_WAIT, timeout counter loaded with 0.
- DM_RD: stall=1. Select lanes from dm_rdata, extend per size/sign_ext, and register the result into rdata. Next state DONE.
- DEV_WAIT: dev_req=1, stall=1, counter increments.
  - dev_ready=1: register dev_rdata (loads), next state DONE.
  - Counter reaches DEV_TIMEOUT-1 without dev_ready: latch a bus error, next state DONE.
- DONE: stall=0. rdata is valid; excode=7 if a bus error was latched. Next state IDLE.
- flush=1 in any state: next state IDLE, stall=0, dev_req=0, no write strobe that cycle. Flush has priority over dev_ready.
- req=0 in IDLE: no strobes and no state change.

## Timing
- Reset values: state IDLE, rdata 0, counter 0, bus-error flag 0. All outputs read 0 / inactive.
- DM store: 0 stall cycles.
- DM load: 2 stall cycles; data is in the third cycle (DONE).
- Timer access: 1 + k stall cycles, where k = cycles until dev_ready. Bus error after DEV_TIMEOUT stall cycles.
- dev_req, dev_we, dev_sel, dev_reg and dev_wdata are held stable from DEV_WAIT entry until dev_ready or abort.
- Reset asserted mid-access: immediate return to IDLE, outputs inactive. No partial write is issued afterwards.
- dev_ready seen in the same cycle as the counter limit: the access completes normally (ready wins over timeout).

## Structure
- Shared package `bus_pkg`:
  - state encoding;
  - size codes;
  - excode constants EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7;
  - the default address-map constants.
- Sub-module `load_align`: combinational lane select plus sign/zero extension from (word, addr[1:0], size, sign_ext). It is reused for the DM and device paths.

## Test plan
- sw 0x12345678 to 0x0010 -> dm_we=1, dm_be=1111, stall=0. Then lw 0x0010 -> stall for 2 cycles, rdata=0x12345678 in DONE.
- sb 0xAB to 0x0013, then lb/lbu 0x0013 -> dm_be=1000. rdata=0xFFFFFFAB for lb and 0x000000AB for lbu.
- lw 0x0002 -> excode=4, stall=0. sh 0x7f04 -> excode=5. sw 0x7f08 -> excode=5. lw 0x3000 -> excode=4. No strobes in any case.
- lw 0x7f14 with dev_ready after 3 cycles -> dev_sel=1, dev_reg=1. stall=1 for 4 cycles, then rdata=dev_rdata.
- sw 0x7f00 with dev_ready never asserted -> DEV_TIMEOUT stall cycles, then excode=7 in DONE, dev_req drops.
- flush (or reset low) during DEV_WAIT -> next cycle state IDLE, stall=0, dev_req=0. A following DM load behaves normally.
